// File: rtl/dnn_layer2_mac_if.sv
// Bundle between the layer-1 stage (master) and the layer-2 MAC (slave):
// activations, weights, results, status and FSM debug state.
interface dnn_layer2_mac_if #(
  parameter int IN_W   = 21,
  parameter int W_W    = 5,
  parameter int ACC_W  = 28,
  parameter int DROP_W = 8
) ();
  logic signed [IN_W-1:0]  y0, y1, y2, y3;
  logic                    stg_2_rdy;
  logic signed [W_W-1:0]   w48, w58, w68, w78;
  logic signed [W_W-1:0]   w49, w59, w69, w79;
  logic signed [ACC_W-1:0] z8, z9;
  logic                    stg_3_rdy;
  logic                    busy;
  logic [DROP_W-1:0]       drop_cnt;
  logic [1:0]              dbg_state;

  // Handshake: stg_2_rdy is a level-valid with no ready; a sample presented
  // while busy is high is dropped and counted. stg_3_rdy is a one-cycle
  // strobe marking new z8/z9, which then hold until the next strobe.
  modport master (
    output y0, y1, y2, y3, stg_2_rdy,
    output w48, w58, w68, w78, w49, w59, w69, w79,
    input  z8, z9, stg_3_rdy, busy, drop_cnt, dbg_state
  );

  modport slave (
    input  y0, y1, y2, y3, stg_2_rdy,
    input  w48, w58, w68, w78, w49, w59, w69, w79,
    output z8, z9, stg_3_rdy, busy, drop_cnt, dbg_state
  );
endinterface

// File: rtl/dnn_layer2_mac.sv
// Output layer of the DNN: z8 and z9 as 4-term dot products computed over
// 8 cycles with one shared multiplier, then presented with a one-cycle strobe.
module dnn_layer2_mac #(
  parameter int IN_W   = 21,
  parameter int W_W    = 5,
  parameter int ACC_W  = 28,
  parameter int RELU   = 0,
  parameter int DROP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  dnn_layer2_mac_if.slave  bus
);

  localparam int P_W = IN_W + W_W;

  typedef enum logic [1:0] {IDLE, MAC8, MAC9, DONE} state_t;

  state_t                  state;
  logic [1:0]              idx;
  logic signed [IN_W-1:0]  ycap  [4];
  logic signed [W_W-1:0]   w8cap [4];
  logic signed [W_W-1:0]   w9cap [4];
  logic signed [ACC_W-1:0] acc8, acc9;

  logic signed [IN_W-1:0]  mul_a;
  logic signed [W_W-1:0]   mul_b;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;

  // The single multiplier walks the captured vector; the weight column
  // follows the neuron currently being accumulated.
  always_comb begin
    mul_a = ycap[idx];
    mul_b = (state == MAC9) ? w9cap[idx] : w8cap[idx];
  end

  assign prod     = P_W'(mul_a) * P_W'(mul_b);
  assign prod_ext = ACC_W'(prod);

  function automatic logic signed [ACC_W-1:0] activate(input logic signed [ACC_W-1:0] v);
    if (RELU != 0 && v[ACC_W-1]) return '0;
    return v;
  endfunction

  assign bus.busy      = (state != IDLE);
  assign bus.dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 2'd0;
      acc8          <= '0;
      acc9          <= '0;
      bus.z8        <= '0;
      bus.z9        <= '0;
      bus.stg_3_rdy <= 1'b0;
      bus.drop_cnt  <= '0;
      for (int i = 0; i < 4; i++) begin
        ycap[i]  <= '0;
        w8cap[i] <= '0;
        w9cap[i] <= '0;
      end
    end else begin
      bus.stg_3_rdy <= 1'b0;

      if (bus.stg_2_rdy && state != IDLE && bus.drop_cnt != {DROP_W{1'b1}})
        bus.drop_cnt <= bus.drop_cnt + DROP_W'(1);

      case (state)
        IDLE: begin
          if (bus.stg_2_rdy) begin
            ycap[0]  <= bus.y0;
            ycap[1]  <= bus.y1;
            ycap[2]  <= bus.y2;
            ycap[3]  <= bus.y3;
            w8cap[0] <= bus.w48;
            w8cap[1] <= bus.w58;
            w8cap[2] <= bus.w68;
            w8cap[3] <= bus.w78;
            w9cap[0] <= bus.w49;
            w9cap[1] <= bus.w59;
            w9cap[2] <= bus.w69;
            w9cap[3] <= bus.w79;
            acc8     <= '0;
            acc9     <= '0;
            idx      <= 2'd0;
            state    <= MAC8;
          end
        end
        MAC8: begin
          acc8 <= acc8 + prod_ext;
          idx  <= idx + 2'd1;
          if (idx == 2'd3) state <= MAC9;
        end
        MAC9: begin
          acc9 <= acc9 + prod_ext;
          idx  <= idx + 2'd1;
          if (idx == 2'd3) state <= DONE;
        end
        DONE: begin
          bus.z8        <= activate(acc8);
          bus.z9        <= activate(acc9);
          bus.stg_3_rdy <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_layer2_mac.sv
// Bench for dnn_layer2_mac: a RELU=0 and a RELU=1 instance share one stimulus
// stream and are compared every cycle against a cycle-count reference model.
module tb_dnn_layer2_mac;

  localparam int IN_W   = 21;
  localparam int W_W    = 5;
  localparam int ACC_W  = 28;
  localparam int DROP_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dnn_layer2_mac_if #(.IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W), .DROP_W(DROP_W)) ifc0 ();
  dnn_layer2_mac_if #(.IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W), .DROP_W(DROP_W)) ifc1 ();

  assign ifc1.y0 = ifc0.y0;
  assign ifc1.y1 = ifc0.y1;
  assign ifc1.y2 = ifc0.y2;
  assign ifc1.y3 = ifc0.y3;
  assign ifc1.stg_2_rdy = ifc0.stg_2_rdy;
  assign ifc1.w48 = ifc0.w48;
  assign ifc1.w58 = ifc0.w58;
  assign ifc1.w68 = ifc0.w68;
  assign ifc1.w78 = ifc0.w78;
  assign ifc1.w49 = ifc0.w49;
  assign ifc1.w59 = ifc0.w59;
  assign ifc1.w69 = ifc0.w69;
  assign ifc1.w79 = ifc0.w79;

  dnn_layer2_mac #(.IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W), .RELU(0), .DROP_W(DROP_W))
    dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
  dnn_layer2_mac #(.IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W), .RELU(1), .DROP_W(DROP_W))
    dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
    return (v > 0) ? v : '0;
  endfunction

  // ---------------- reference model ----------------
  // Timing is tracked as edge numbers: a capture at edge E blocks new captures
  // until E+10 and delivers its result in the cycle after edge E+9.
  logic [2*ACC_W-1:0]      exp_q[$];
  int unsigned             due_q[$];
  int unsigned             edge_n    = 0;
  int unsigned             cap_e     = 0;
  bit                      have_cap  = 1'b0;
  longint                  exp_drop  = 0;
  logic signed [ACC_W-1:0] held8     = '0;
  logic signed [ACC_W-1:0] held9     = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      edge_n   = 0;
      have_cap = 1'b0;
      exp_drop = 0;
      held8    = '0;
      held9    = '0;
    end else begin
      edge_n++;
      if (ifc0.stg_2_rdy) begin
        if (!have_cap || edge_n >= cap_e + 10) begin
          longint s8, s9;
          s8 = longint'(ifc0.y0) * longint'(ifc0.w48) + longint'(ifc0.y1) * longint'(ifc0.w58)
             + longint'(ifc0.y2) * longint'(ifc0.w68) + longint'(ifc0.y3) * longint'(ifc0.w78);
          s9 = longint'(ifc0.y0) * longint'(ifc0.w49) + longint'(ifc0.y1) * longint'(ifc0.w59)
             + longint'(ifc0.y2) * longint'(ifc0.w69) + longint'(ifc0.y3) * longint'(ifc0.w79);
          exp_q.push_back({ACC_W'(s8), ACC_W'(s9)});
          due_q.push_back(edge_n + 9);
          cap_e    = edge_n;
          have_cap = 1'b1;
        end else if (exp_drop < (1 << DROP_W) - 1) begin
          exp_drop++;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [2*ACC_W-1:0] r;
    bit exp_rdy;
    bit exp_busy;
    exp_rdy  = (due_q.size() > 0) && (due_q[0] == edge_n) && !rst;
    exp_busy = have_cap && (edge_n < cap_e + 9) && !rst;
    if (exp_rdy) begin
      r = exp_q.pop_front();
      void'(due_q.pop_front());
      held8 = r[2*ACC_W-1:ACC_W];
      held9 = r[ACC_W-1:0];
    end
    check("stg_3_rdy",      ifc0.stg_3_rdy, exp_rdy);
    check("stg_3_rdy_relu", ifc1.stg_3_rdy, exp_rdy);
    check("z8",             ifc0.z8,        held8);
    check("z9",             ifc0.z9,        held9);
    check("z8_relu",        ifc1.z8,        relu(held8));
    check("z9_relu",        ifc1.z9,        relu(held9));
    check("busy",           ifc0.busy,      exp_busy);
    check("drop_cnt",       ifc0.drop_cnt,  exp_drop);
  end

  // ---------------- driver tasks ----------------
  logic signed [IN_W-1:0] ty  [4];
  logic signed [W_W-1:0]  tw8 [4];
  logic signed [W_W-1:0]  tw9 [4];

  task automatic apply();
    ifc0.y0  = ty[0];  ifc0.y1  = ty[1];  ifc0.y2  = ty[2];  ifc0.y3  = ty[3];
    ifc0.w48 = tw8[0]; ifc0.w58 = tw8[1]; ifc0.w68 = tw8[2]; ifc0.w78 = tw8[3];
    ifc0.w49 = tw9[0]; ifc0.w59 = tw9[1]; ifc0.w69 = tw9[2]; ifc0.w79 = tw9[3];
  endtask

  task automatic set_all(input int yv, input int wv);
    for (int i = 0; i < 4; i++) begin
      ty[i]  = IN_W'(yv);
      tw8[i] = W_W'(wv);
      tw9[i] = W_W'(wv);
    end
  endtask

  // Returns on the negedge after the last stg_2_rdy=1 edge.
  task automatic pulse(input int n);
    @(negedge clk);
    apply();
    ifc0.stg_2_rdy = 1'b1;
    repeat (n) @(negedge clk);
    ifc0.stg_2_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    set_all(0, 0);
    apply();
    ifc0.stg_2_rdy = 1'b0;
    #1 rst = 1'b1;
    idle(3);
    check("rst_z8",    ifc0.z8, 0);
    check("rst_busy",  ifc0.busy, 0);
    check("rst_drop",  ifc0.drop_cnt, 0);
    check("rst_rdy",   ifc0.stg_3_rdy, 0);
    rst = 1'b0;
    idle(2);

    // Basic dot products and latency
    ty  = '{21'sd1, 21'sd2, 21'sd3, 21'sd4};
    tw8 = '{5'sd1, 5'sd1, 5'sd1, 5'sd1};
    tw9 = '{5'sd2, -5'sd1, 5'sd0, 5'sd3};
    pulse(1);
    check("tp1_busy_e0", ifc0.busy, 1);
    idle(8);
    check("tp1_busy_e8", ifc0.busy, 1);
    check("tp1_rdy_e8",  ifc0.stg_3_rdy, 0);
    idle(1);
    check("tp1_rdy_e9",  ifc0.stg_3_rdy, 1);
    check("tp1_busy_e9", ifc0.busy, 0);
    check("tp1_z8",      ifc0.z8, 10);
    check("tp1_z9",      ifc0.z9, 12);
    idle(1);
    check("tp1_rdy_e10", ifc0.stg_3_rdy, 0);
    idle(2);

    // Negative result, ReLU on/off
    ty  = '{21'sd100, 21'sd0, 21'sd0, 21'sd0};
    tw8 = '{-5'sd16, 5'sd0, 5'sd0, 5'sd0};
    tw9 = '{5'sd5, 5'sd0, 5'sd0, 5'sd0};
    pulse(1);
    idle(9);
    check("tp2_z8",      ifc0.z8, -1600);
    check("tp2_z9",      ifc0.z9, 500);
    check("tp2_z8_relu", ifc1.z8, 0);
    check("tp2_z9_relu", ifc1.z9, 500);
    idle(2);

    // Extremes
    set_all(1048575, -16);
    pulse(1);
    idle(9);
    check("tp3_min_z8", ifc0.z8, -67108800);
    check("tp3_min_z9", ifc0.z9, -67108800);
    idle(2);
    set_all(1048575, 15);
    pulse(1);
    idle(9);
    check("tp3_max_z8", ifc0.z8, 62914500);
    check("tp3_max_z9", ifc0.z9, 62914500);
    idle(2);

    // Held-high stg_2_rdy: captures every 10 edges, rest are drops
    set_all(3, -2);
    pulse(25);
    idle(5);
    check("tp4_rdy_e29", ifc0.stg_3_rdy, 1);
    check("tp4_drop",    ifc0.drop_cnt, 22);
    idle(2);

    // Inputs changing after capture do not affect the result
    set_all(1, 1);
    pulse(1);
    idle(1);
    set_all(7, 7);
    apply();
    idle(8);
    check("tp5_z8", ifc0.z8, 4);
    check("tp5_z9", ifc0.z9, 4);
    idle(2);

    // Asynchronous reset mid-computation
    set_all(5, 3);
    pulse(1);
    idle(6);
    #2 rst = 1'b1;
    #1;
    check("tp6_z8_now",   ifc0.z8, 0);
    check("tp6_z9_now",   ifc0.z9, 0);
    check("tp6_busy_now", ifc0.busy, 0);
    check("tp6_drop_now", ifc0.drop_cnt, 0);
    idle(3);
    rst = 1'b0;
    idle(12);
    ty  = '{21'sd1, 21'sd2, 21'sd3, 21'sd4};
    tw8 = '{5'sd1, 5'sd1, 5'sd1, 5'sd1};
    tw9 = '{5'sd2, -5'sd1, 5'sd0, 5'sd3};
    pulse(1);
    idle(9);
    check("tp6_after_rdy", ifc0.stg_3_rdy, 1);
    check("tp6_after_z8",  ifc0.z8, 10);
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 4; i++) begin
        ty[i]  = IN_W'($urandom_range(0, (1 << IN_W) - 1));
        tw8[i] = W_W'($urandom_range(0, (1 << W_W) - 1));
        tw9[i] = W_W'($urandom_range(0, (1 << W_W) - 1));
      end
      pulse($urandom_range(1, 14));
      idle($urandom_range(0, 12));
    end
    idle(12);

    // Drop counter saturation
    set_all(9, -9);
    pulse(300);
    idle(12);
    check("sat_drop", ifc0.drop_cnt, 255);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
